dsa_issuer: RTL
===============

# dsa_issuer

Bus initiator that drives the operand/result register window of the DSA data feeder at `BASE_ADDR`. It accepts one three-operand job on a valid/ready command port and performs three single-cycle writes (A, B, C). It then waits a fixed settle time and polls the result register until the feeder reports ready or a poll limit expires. The result, or a timeout error, is returned on a valid/ready response port. It sits between a job source (CPU-side command queue or test harness) and the feeder's device port, replacing software-driven polling.

## Interface
Parameters:
- `XLEN`, 32, data and address width.
- `BASE_ADDR`, 32'hC4000000, feeder window base. Result is at +0x0, A at +0x4, B at +0x8, C at +0xC.
- `SETTLE`, 4, idle cycles between the C write and the first read strobe. 0 is legal.
- `MAX_POLL`, 16, read attempts before timeout. Must be ≥1.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cmd_valid_i` in 1: job offered.
- `cmd_ready_o` out 1: job accepted when both are high.
- `cmd_a_i`, `cmd_b_i`, `cmd_c_i` in XLEN each: operands.
- `M_DEVICE_strobe_o` out 1: one-cycle access strobe.
- `M_DEVICE_addr_o` out XLEN: access address.
- `M_DEVICE_rw_o` out 1: 1 = write, 0 = read.
- `M_DEVICE_data_o` out XLEN: write data.
- `M_DEVICE_ready_i` in 1: feeder result-valid indication.
- `M_DEVICE_data_i` in XLEN: feeder read data.
- `rsp_valid_o` out 1: response available.
- `rsp_ready_i` in 1: response consumed when both are high.
- `rsp_data_o` out XLEN: result.
- `rsp_err_o` out 1: 1 = poll timeout. `rsp_data_o` is then 0.

## Operation
- States: IDLE, WR_A, WR_B, WR_C, WAIT, RD_REQ, RD_CHK, RESP.
- IDLE:
  - `cmd_ready_o` = 1; it is 0 in every other state.
  - On handshake, latch A/B/C into internal registers, then go to WR_A.
  - The command is sampled only in IDLE; inputs are ignored elsewhere.
- WR_A, WR_B, WR_C:
  - Each lasts exactly one cycle with strobe = 1, rw = 1, address = base + 4/8/C, data = the latched operand.
  - `M_DEVICE_ready_i` is not waited on for writes.
  - WR_C goes to WAIT, or directly to RD_REQ if `SETTLE` = 0.
- WAIT:
  - The settle counter loads `SETTLE`−1 on entry and decrements each cycle.
  - Go to RD_REQ when it reaches 0.
  - Strobe is 0.
- RD_REQ: one cycle with strobe = 1, rw = 0, address = base + 0, data = 0. Go to RD_CHK.
- RD_CHK (strobe = 0):
  - If `M_DEVICE_ready_i` = 1: capture `M_DEVICE_data_i` into the result register, set err = 0, go to RESP.
  - Otherwise increment the poll counter.
    - If the count of completed attempts equals `MAX_POLL`: result = 0, err = 1, go to RESP.
    - Else go back to RD_REQ.
- RESP:
  - `rsp_valid_o` = 1 with data and err held stable until `rsp_ready_i`.
  - On handshake, clear the poll counter and go to IDLE.
  - A new command can be accepted on the cycle after the response handshake, never the same cycle.
- Bus outputs are Moore outputs decoded from the state and latched registers only. There is no combinational path from any input to any output.
- Counter widths: `$clog2(SETTLE+1)` and `$clog2(MAX_POLL+1)`. Neither counter wraps.

## Timing
- Reset values (asynchronous, take effect immediately):
  - state = IDLE.
  - `cmd_ready_o` = 1.
  - `M_DEVICE_strobe_o` = 0, `M_DEVICE_rw_o` = 0, `M_DEVICE_addr_o` = 0, `M_DEVICE_data_o` = 0.
  - `rsp_valid_o` = 0, `rsp_data_o` = 0, `rsp_err_o` = 0.
  - All counters and latches = 0.
- Reset mid-job aborts the transaction. No further strobes occur, and the job is lost with no response.
- Best-case latency, with the handshake at cycle T:
  - write strobes at T+1, T+2, T+3;
  - read strobe at T+4+`SETTLE`;
  - ready checked at T+5+`SETTLE`;
  - `rsp_valid_o` high at T+6+`SETTLE`.
- Each failed poll adds 2 cycles.
- Timeout: `rsp_valid_o` rises 2·`MAX_POLL` cycles after the first read strobe (single-cycle RESP entry).
- The read-data sample in RD_CHK is the feeder output registered from the preceding RD_REQ strobe.
- `rsp_ready_i` held high before RESP: the response completes in one cycle.

## Structure
- Shared header/package `dsa_pkg` holds:
  - the register offsets (`DSA_OUT_OFS` = 0x0, `DSA_IN1_OFS` = 0x4, `DSA_IN2_OFS` = 0x8, `DSA_IN3_OFS` = 0xC);
  - the state encoding.
- The feeder and this block both use these definitions.
- Single flat module; no sub-module is warranted.

## Test plan
- Basic job: `SETTLE` = 4, A/B/C = 0x3F800000/0x40000000/0x40400000, feeder model returns ready with 0x40A00000 on the first poll.
  - Required: writes to 0xC4000004/8/C on T+1..T+3, read strobe at T+8, `rsp_valid_o` at T+10 with data 0x40A00000 and err = 0.
- Slow result: ready asserts only on the third poll.
  - Required: exactly 3 read strobes spaced 2 cycles apart, then a correct response with err = 0.
- Timeout: `MAX_POLL` = 16, ready never asserts.
  - Required: exactly 16 read strobes, then a response with data = 0 and err = 1.
- Backpressure: hold `rsp_ready_i` = 0 for 5 cycles.
  - Required: response stable throughout, `cmd_ready_o` = 0, no strobes.
  - Then two back-to-back jobs: the second is accepted the cycle after the first response handshake.
- `SETTLE` = 0: read strobe on the cycle immediately after the C write (T+4).
- Async reset asserted during WAIT: all outputs go to reset values without a clock edge, and no strobe follows after release until a new command arrives.

Source files
------------

// File: rtl/dsa_pkg.sv
// dsa_pkg: feeder register map and issuer state encoding shared by feeder and issuer
package dsa_pkg;
  localparam logic [31:0] DSA_OUT_OFS = 32'h0;
  localparam logic [31:0] DSA_IN1_OFS = 32'h4;
  localparam logic [31:0] DSA_IN2_OFS = 32'h8;
  localparam logic [31:0] DSA_IN3_OFS = 32'hC;
  typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_C, WAIT, RD_REQ, RD_CHK, RESP} dsa_state_t;
endpackage

// File: rtl/dsa_issuer_if.sv
// dsa_issuer_if: single-cycle strobe bus between the issuer and the feeder device port
interface dsa_issuer_if #(parameter int XLEN = 32);
  logic            strobe;
  logic [XLEN-1:0] addr;
  logic            rw;
  logic [XLEN-1:0] wdata;
  logic            ready;
  logic [XLEN-1:0] rdata;
  modport master (output strobe, addr, rw, wdata, input ready, rdata);
  modport slave  (input strobe, addr, rw, wdata, output ready, rdata);
endinterface

// File: rtl/dsa_issuer.sv
// dsa_issuer: writes a three-operand job to the feeder, polls the result, returns it or a timeout
module dsa_issuer
  import dsa_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'hC4000000,
  parameter int              SETTLE    = 4,
  parameter int              MAX_POLL  = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [XLEN-1:0] cmd_a_i,
  input  logic [XLEN-1:0] cmd_b_i,
  input  logic [XLEN-1:0] cmd_c_i,
  dsa_issuer_if.master    M_DEVICE,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            rsp_err_o
);
  localparam int SW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  localparam int PW = $clog2(MAX_POLL + 1);
  dsa_state_t      state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, c_q, c_d, res_q, res_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic            err_q, err_d;
  // state, operand latches, counters and result register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      res_q    <= '0;
      settle_q <= '0;
      poll_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      res_q    <= res_d;
      settle_q <= settle_d;
      poll_q   <= poll_d;
      err_q    <= err_d;
    end
  end
  // next-state: write A/B/C, settle, then alternate read strobe and ready check until done
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    res_d    = res_q;
    settle_d = settle_q;
    poll_d   = poll_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        a_d     = cmd_a_i;
        b_d     = cmd_b_i;
        c_d     = cmd_c_i;
        state_d = WR_A;
      end
      WR_A: state_d = WR_B;
      WR_B: state_d = WR_C;
      WR_C: begin
        settle_d = SW'(SETTLE - 1);
        state_d  = SETTLE == 0 ? RD_REQ : WAIT;
      end
      WAIT: begin
        settle_d = settle_q == '0 ? settle_q : settle_q - 1'b1;
        state_d  = settle_q == '0 ? RD_REQ : WAIT;
      end
      RD_REQ: state_d = RD_CHK;
      RD_CHK: if (M_DEVICE.ready) begin
        res_d   = M_DEVICE.rdata;
        err_d   = 1'b0;
        state_d = RESP;
      end else begin
        poll_d  = poll_q + 1'b1;
        res_d   = '0;
        err_d   = poll_d == PW'(MAX_POLL);
        state_d = poll_d == PW'(MAX_POLL) ? RESP : RD_REQ;
      end
      RESP: if (rsp_ready_i) begin
        poll_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Moore outputs decoded from state and latched operands only
  always_comb begin
    cmd_ready_o     = state_q == IDLE;
    M_DEVICE.strobe = state_q inside {WR_A, WR_B, WR_C, RD_REQ};
    M_DEVICE.rw     = state_q inside {WR_A, WR_B, WR_C};
    M_DEVICE.addr   = state_q == WR_A   ? BASE_ADDR + XLEN'(DSA_IN1_OFS) :
                      state_q == WR_B   ? BASE_ADDR + XLEN'(DSA_IN2_OFS) :
                      state_q == WR_C   ? BASE_ADDR + XLEN'(DSA_IN3_OFS) :
                      state_q == RD_REQ ? BASE_ADDR + XLEN'(DSA_OUT_OFS) : '0;
    M_DEVICE.wdata  = state_q == WR_A ? a_q : state_q == WR_B ? b_q : state_q == WR_C ? c_q : '0;
    rsp_valid_o     = state_q == RESP;
    rsp_data_o      = state_q == RESP ? res_q : '0;
    rsp_err_o       = state_q == RESP && err_q;
  end
endmodule
